// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, memory and status signals of the memory port arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_rw;
  logic              d_byte;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_enable;
  logic              mem_rw;
  logic              mem_byte;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              moc;

  logic              owner;
  logic              busy;
  logic              err;

  // slave: the arbiter's view
  modport slave (
    input  if_req, if_addr, d_req, d_rw, d_byte, d_addr, d_wdata, mem_rdata, moc,
    output if_done, if_rdata, d_done, d_rdata, mem_enable, mem_rw, mem_byte,
           mem_addr, mem_wdata, owner, busy, err
  );

  // master: the requesters' and memory's view
  modport master (
    output if_req, if_addr, d_req, d_rw, d_byte, d_addr, d_wdata, mem_rdata, moc,
    input  if_done, if_rdata, d_done, d_rdata, mem_enable, mem_rw, mem_byte,
           mem_addr, mem_wdata, owner, busy, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data access
// Optional watchdog abort on missing MOC is enabled by defining MEM_WATCHDOG_EN.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t            r_state,      w_state_nxt;
  logic              r_owner,      w_owner_nxt;
  logic              r_last_owner, w_last_owner_nxt;
  logic              r_busy,       w_busy_nxt;
  logic              r_mem_enable, w_mem_enable_nxt;
  logic              r_mem_rw,     w_mem_rw_nxt;
  logic              r_mem_byte,   w_mem_byte_nxt;
  logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata,  w_mem_wdata_nxt;
  logic [DATA_W-1:0] r_if_rdata,   w_if_rdata_nxt;
  logic [DATA_W-1:0] r_d_rdata,    w_d_rdata_nxt;
  logic              r_if_done,    w_if_done_nxt;
  logic              r_d_done,     w_d_done_nxt;
  logic              r_err,        w_err_nxt;
  logic              w_grant_data;
  logic              w_timeout;

  // Data wins when it asks alone, or when both ask and fetch was served last
  assign w_grant_data = bus.d_req & (~bus.if_req | ~r_last_owner);

`ifdef MEM_WATCHDOG_EN
  localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [WD_W-1:0] r_wd_cnt;

  assign w_timeout = (r_wd_cnt == WD_W'(TIMEOUT - 1));

  // Count cycles spent in ACCESS; held at zero elsewhere so each access starts from zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  r_wd_cnt <= '0;
    else if (r_state != S_ACCESS) r_wd_cnt <= '0;
    else                         r_wd_cnt <= r_wd_cnt + WD_W'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next state and next values of every registered output
  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_busy_nxt       = r_busy;
    w_mem_enable_nxt = r_mem_enable;
    w_mem_rw_nxt     = r_mem_rw;
    w_mem_byte_nxt   = r_mem_byte;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_if_rdata_nxt   = r_if_rdata;
    w_d_rdata_nxt    = r_d_rdata;
    w_if_done_nxt    = 1'b0;
    w_d_done_nxt     = 1'b0;
    w_err_nxt        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          w_owner_nxt      = w_grant_data;
          w_mem_addr_nxt   = w_grant_data ? bus.d_addr : bus.if_addr;
          w_mem_wdata_nxt  = w_grant_data ? bus.d_wdata : '0;
          w_mem_rw_nxt     = w_grant_data & bus.d_rw;
          w_mem_byte_nxt   = w_grant_data & bus.d_byte;
          w_mem_enable_nxt = 1'b1;
          w_busy_nxt       = 1'b1;
          w_state_nxt      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (bus.moc || w_timeout) begin
          // Only a real completion of a read updates the requester's data
          if (bus.moc && !r_mem_rw) begin
            if (r_owner) w_d_rdata_nxt  = bus.mem_rdata;
            else         w_if_rdata_nxt = bus.mem_rdata;
          end
          w_if_done_nxt    = ~r_owner;
          w_d_done_nxt     = r_owner;
          w_err_nxt        = ~bus.moc;
          w_mem_enable_nxt = 1'b0;
          w_last_owner_nxt = r_owner;
          w_state_nxt      = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Hold off new grants until memory drops MOC
        if (!bus.moc) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_busy_nxt       = 1'b0;
        w_mem_enable_nxt = 1'b0;
        w_state_nxt      = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access without a done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b0;
      r_busy       <= 1'b0;
      r_mem_enable <= 1'b0;
      r_mem_rw     <= 1'b0;
      r_mem_byte   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_if_done    <= 1'b0;
      r_d_done     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_busy       <= w_busy_nxt;
      r_mem_enable <= w_mem_enable_nxt;
      r_mem_rw     <= w_mem_rw_nxt;
      r_mem_byte   <= w_mem_byte_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_if_rdata   <= w_if_rdata_nxt;
      r_d_rdata    <= w_d_rdata_nxt;
      r_if_done    <= w_if_done_nxt;
      r_d_done     <= w_d_done_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign bus.if_done    = r_if_done;
  assign bus.if_rdata   = r_if_rdata;
  assign bus.d_done     = r_d_done;
  assign bus.d_rdata    = r_d_rdata;
  assign bus.mem_enable = r_mem_enable;
  assign bus.mem_rw     = r_mem_rw;
  assign bus.mem_byte   = r_mem_byte;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.owner      = r_owner;
  assign bus.busy       = r_busy;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int TMO = 8;
`ifdef MEM_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errs = 0;
  int   n_if_done = 0;
  int   n_d_done = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: at most one transaction open on the port, plus who was served last
  logic        m_open = 0, m_drain = 0, m_served_data = 0;
  int          m_age = 0;
  logic        e_owner = 0, e_rw = 0, e_byte = 0, e_en = 0;
  logic        e_if_done = 0, e_d_done = 0, e_err = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_if_rdata = 0, e_d_rdata = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_open = 0; m_drain = 0; m_served_data = 0; m_age = 0;
      e_owner = 0; e_rw = 0; e_byte = 0; e_en = 0;
      e_if_done = 0; e_d_done = 0; e_err = 0;
      e_addr = 0; e_wdata = 0; e_if_rdata = 0; e_d_rdata = 0;
    end else begin
      e_if_done = 0; e_d_done = 0; e_err = 0;
      if (m_open) begin
        m_age++;
        if (bus.moc || (WD && m_age == TMO)) begin
          if (bus.moc && !e_rw) begin
            if (e_owner) e_d_rdata = bus.mem_rdata;
            else         e_if_rdata = bus.mem_rdata;
          end
          e_err = !bus.moc;
          if (e_owner) e_d_done = 1; else e_if_done = 1;
          e_en = 0; m_open = 0; m_drain = 1; m_served_data = e_owner;
        end
      end else if (m_drain) begin
        if (!bus.moc) m_drain = 0;
      end else if (bus.if_req || bus.d_req) begin
        e_owner = bus.d_req && !(bus.if_req && m_served_data);
        e_addr  = e_owner ? bus.d_addr : bus.if_addr;
        e_wdata = e_owner ? bus.d_wdata : 32'h0;
        e_rw    = e_owner && bus.d_rw;
        e_byte  = e_owner && bus.d_byte;
        e_en = 1; m_open = 1; m_age = 0;
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    chk1("busy", bus.busy, m_open | m_drain);
    chk1("mem_enable", bus.mem_enable, e_en);
    chk1("if_done", bus.if_done, e_if_done);
    chk1("d_done", bus.d_done, e_d_done);
    chk1("err", bus.err, e_err);
    chk32("if_rdata", bus.if_rdata, e_if_rdata);
    chk32("d_rdata", bus.d_rdata, e_d_rdata);
    if (m_open || m_drain) begin
      chk1("owner", bus.owner, e_owner);
      chk1("mem_rw", bus.mem_rw, e_rw);
      chk1("mem_byte", bus.mem_byte, e_byte);
      chk32("mem_addr", bus.mem_addr, e_addr);
      chk32("mem_wdata", bus.mem_wdata, e_wdata);
    end
    if (reset && bus.if_done) n_if_done++;
    if (reset && bus.d_done)  n_d_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(input string nm);
    int n;
    n = 0;
    while (bus.mem_enable !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk1(nm, bus.mem_enable, 1'b1);
  endtask

  // Memory answers after `waits` cycles; returns just after the done edge
  task automatic complete(input int waits, input logic [31:0] rd);
    repeat (waits) tick();
    bus.moc = 1'b1;
    bus.mem_rdata = rd;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench time limit");
  end

  initial begin
    int c_if, c_d;
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_rw = 0; bus.d_byte = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0; bus.moc = 0;
    repeat (2) tick();
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_enable", bus.mem_enable, 1'b0);
    chk1("rst_err", bus.err, 1'b0);
    chk32("rst_if_rdata", bus.if_rdata, 32'h0);
    chk32("rst_d_rdata", bus.d_rdata, 32'h0);
    reset = 1;
    tick();

    // moc while idle is ignored
    bus.moc = 1; bus.mem_rdata = 32'h55;
    repeat (2) tick();
    chk1("idle_moc_busy", bus.busy, 1'b0);
    chk32("idle_moc_if_rdata", bus.if_rdata, 32'h0);
    bus.moc = 0;
    tick();

    // Simultaneous requests from reset: data first, then fetch
    c_if = n_if_done; c_d = n_d_done;
    bus.if_req = 1; bus.if_addr = 32'h100;
    bus.d_req = 1; bus.d_rw = 0; bus.d_byte = 0; bus.d_addr = 32'h200;
    wait_en("t3_en1");
    chk1("t3_first_owner", bus.owner, 1'b1);
    chk32("t3_addr1", bus.mem_addr, 32'h200);
    complete(1, 32'hA5A5_0001);
    chk1("t3_d_done", bus.d_done, 1'b1);
    chk32("t3_d_rdata", bus.d_rdata, 32'hA5A5_0001);
    bus.d_req = 0; bus.moc = 0;
    wait_en("t3_en2");
    chk1("t3_second_owner", bus.owner, 1'b0);
    chk32("t3_addr2", bus.mem_addr, 32'h100);
    complete(2, 32'h0F0F_0002);
    chk1("t3_if_done", bus.if_done, 1'b1);
    chk32("t3_if_rdata", bus.if_rdata, 32'h0F0F_0002);
    bus.if_req = 0; bus.moc = 0;
    repeat (2) tick();
    chk32("t3_if_done_count", 32'(n_if_done - c_if), 32'd1);
    chk32("t3_d_done_count", 32'(n_d_done - c_d), 32'd1);

    // Fetch only; address change during access is ignored
    c_if = n_if_done;
    bus.if_req = 1; bus.if_addr = 32'h10;
    wait_en("t1_en");
    chk1("t1_rw", bus.mem_rw, 1'b0);
    chk1("t1_byte", bus.mem_byte, 1'b0);
    chk32("t1_addr", bus.mem_addr, 32'h10);
    bus.if_addr = 32'h99;
    complete(3, 32'h2002_000A);
    chk1("t1_if_done", bus.if_done, 1'b1);
    chk32("t1_if_rdata", bus.if_rdata, 32'h2002_000A);
    chk1("t1_enable_off", bus.mem_enable, 1'b0);
    chk32("t1_addr_hold", bus.mem_addr, 32'h10);
    bus.if_req = 0; bus.moc = 0;
    repeat (2) tick();
    chk32("t1_done_count", 32'(n_if_done - c_if), 32'd1);

    // Data read with req dropped mid-access still completes
    c_d = n_d_done;
    bus.d_req = 1; bus.d_rw = 0; bus.d_byte = 0; bus.d_addr = 32'h80;
    wait_en("t2r_en");
    bus.d_req = 0;
    complete(2, 32'h1234_5678);
    chk1("t2r_d_done", bus.d_done, 1'b1);
    chk32("t2r_d_rdata", bus.d_rdata, 32'h1234_5678);
    bus.moc = 0;
    repeat (2) tick();
    chk32("t2r_done_count", 32'(n_d_done - c_d), 32'd1);

    // Byte store leaves read data untouched
    bus.d_req = 1; bus.d_rw = 1; bus.d_byte = 1; bus.d_addr = 32'h44; bus.d_wdata = 32'hAB;
    wait_en("t2_en");
    chk32("t2_wdata", bus.mem_wdata, 32'hAB);
    chk1("t2_rw", bus.mem_rw, 1'b1);
    chk1("t2_byte", bus.mem_byte, 1'b1);
    chk1("t2_owner", bus.owner, 1'b1);
    complete(1, 32'hDEAD_BEEF);
    chk1("t2_d_done", bus.d_done, 1'b1);
    chk32("t2_d_rdata_kept", bus.d_rdata, 32'h1234_5678);
    bus.d_req = 0; bus.d_rw = 0; bus.d_byte = 0; bus.moc = 0;
    repeat (2) tick();

    // moc held high after done keeps the port in release
    c_if = n_if_done;
    bus.if_req = 1; bus.if_addr = 32'h20;
    wait_en("t4_en");
    complete(1, 32'h4444_4444);
    chk1("t4_if_done", bus.if_done, 1'b1);
    bus.if_req = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("t4_hold_busy", bus.busy, 1'b1);
      chk1("t4_hold_no_done", bus.if_done, 1'b0);
    end
    bus.moc = 0;
    tick();
    chk1("t4_idle", bus.busy, 1'b0);
    tick();
    chk32("t4_done_count", 32'(n_if_done - c_if), 32'd1);

    // Memory never answers
    bus.if_req = 1; bus.if_addr = 32'h30;
    wait_en("t6_en");
`ifdef MEM_WATCHDOG_EN
    repeat (TMO - 1) begin
      tick();
      chk1("t6_wait_done", bus.if_done, 1'b0);
    end
    tick();
    chk1("t6_wd_done", bus.if_done, 1'b1);
    chk1("t6_wd_err", bus.err, 1'b1);
    chk1("t6_wd_enable_off", bus.mem_enable, 1'b0);
    chk32("t6_wd_rdata_kept", bus.if_rdata, 32'h4444_4444);
`else
    repeat (20) begin
      tick();
      chk1("t6_enable_held", bus.mem_enable, 1'b1);
      chk1("t6_no_err", bus.err, 1'b0);
    end
    complete(0, 32'h0000_6666);
    chk1("t6_late_done", bus.if_done, 1'b1);
    chk32("t6_late_rdata", bus.if_rdata, 32'h0000_6666);
`endif
    bus.if_req = 0; bus.moc = 0;
    repeat (2) tick();

    // Reset during access aborts immediately, then a clean access follows
    c_if = n_if_done;
    bus.if_req = 1; bus.if_addr = 32'h50;
    wait_en("t5_en");
    tick();
    #2 reset = 0;
    #1;
    chk1("t5_enable_cleared", bus.mem_enable, 1'b0);
    chk1("t5_busy_cleared", bus.busy, 1'b0);
    chk32("t5_if_rdata_cleared", bus.if_rdata, 32'h0);
    chk32("t5_d_rdata_cleared", bus.d_rdata, 32'h0);
    bus.if_req = 0;
    repeat (2) tick();
    reset = 1;
    tick();
    chk32("t5_no_done", 32'(n_if_done - c_if), 32'd0);
    bus.if_req = 1; bus.if_addr = 32'h60;
    wait_en("t5_resume_en");
    chk32("t5_resume_addr", bus.mem_addr, 32'h60);
    complete(1, 32'h0BAD_F00D);
    chk1("t5_resume_done", bus.if_done, 1'b1);
    chk32("t5_resume_rdata", bus.if_rdata, 32'h0BAD_F00D);
    bus.if_req = 0; bus.moc = 0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
